calc1_quad_alu: RTL and testbench
=================================

Name: calc1_quad_alu

Overview:
Four-port, 32-bit integer calculator serving four independent requesters. Each port accepts a two-cycle request: command plus operand 1, then operand 2. Each port returns a one-cycle response code with result data. Used as a standalone arithmetic/shift service block.

Parameters:
DATA_W, 32, operand and result width. The bench uses 32 only.

Ports:
- c_clk  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-low (0 = in reset).
- reqN_cmd_in  input  4  command for port N, N=1..4.
- reqN_data_in  input  DATA_W  operand for port N.
- out_dataN  output  DATA_W  result for port N.
- out_respN  output  2  response code for port N.

Vectors are declared [0:W-1]; bit 0 is the MSB.

Behaviour:
- Command codes:
  - 0 no-op
  - 1 add
  - 2 subtract
  - 5 shift left logical
  - 6 shift right logical
  - 3, 4, 7-15 invalid
- Response codes:
  - 0 no response
  - 1 success
  - 2 error (overflow, underflow, or invalid command)
  - 3 reserved, never driven
- Reset (asynchronous assert, synchronous deassert):
  - all out_resp = 0, all out_data = 0.
  - all port FSMs go to IDLE; in-flight requests are discarded with no response.
- Per-port FSM: IDLE -> OP2 -> EXEC -> RESP -> IDLE.
  - IDLE: sample cmd/data each edge. Nonzero cmd latches cmd and op1, go to OP2. Cmd 0 stays IDLE.
  - OP2: the next edge latches data_in as op2, unconditionally. cmd_in is ignored in this cycle.
  - EXEC: result and status are computed and registered.
  - RESP: out_resp/out_data are driven for exactly one cycle, then return to 0.
  - Latency: response is visible in the 3rd cycle after the op2 sampling edge (op2 edge = E, outputs valid after edge E+2, cleared after E+3).
- While a port is not IDLE, nonzero commands on that port are ignored. They get no response and no queueing.
- The next command may be presented in the cycle its response is visible. It is sampled at the edge that clears the response.
- Add:
  - result = op1 + op2 (unsigned).
  - Carry out of bit 0: resp 2, data 0.
  - Otherwise resp 1.
- Subtract:
  - result = op1 - op2 (unsigned).
  - op2 > op1: resp 2, data 0.
  - op1 == op2: resp 1, data 0.
- Shift left / shift right:
  - Shift op1 by op2 low 5 bits (bits [27:31]), zero fill.
  - Upper op2 bits are ignored.
  - Always resp 1.
- Invalid command: op2 is still consumed; resp 2, data 0, same latency.
- out_data is 0 whenever out_resp != 1.
- The four ports are fully independent. Simultaneous requests on all ports complete in the same cycle without interaction.

Decomposition:
- Package calc1_pkg:
  - command localparams: CMD_NOP, CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR.
  - response localparams: RESP_NONE, RESP_OK, RESP_ERR.
  - FSM state enum.
  - DATA_W default.
- Sub-module calc1_port_unit: FSM, operand registers, add/sub/shift datapath, output registers.
- Top instantiates calc1_port_unit four times.

Test Plan:
- Reset held low 4 cycles, then released; all cmds 0 -> all resp 0 and data 0 throughout.
- Port1 add 0x00000001 + 0x1FFFFFFF -> resp1=1, data1=0x20000000 at specified latency. Add 0x1FFFFFFF + 0x1FFFFFFF -> 0x3FFFFFFE. Add 0+0 -> resp 1, data 0.
- Port1 add 0xFFFFFFFF + 1 -> resp 2, data 0. Sub 1 - 15 -> resp 2, data 0. Sub 15 - 1 -> resp 1, data 14.
- Port1 cmd 3 and cmd 4 (op 1, op2 0) -> resp 2, data 0, each exactly one cycle.
- Sweep x = 1,2,4,...,16384: add x + 0 -> data x, resp 1. Shl 1 by 31 -> 0x80000000. Shr 0x80000000 by 0x00000021 -> 0x40000000.
- All four ports issue adds simultaneously, with a second cmd sent during busy (ignored). Assert reset mid-EXEC (no response, outputs 0).

Source files
------------

// File: rtl/calc1_pkg.sv
// Shared constants and types for the four-port calculator.
// Vectors are big-endian indexed ([0:W-1]); bit 0 is the MSB.
package calc1_pkg;

  localparam int DEF_DATA_W = 32;

  localparam logic [0:3] CMD_NOP = 4'd0;
  localparam logic [0:3] CMD_ADD = 4'd1;
  localparam logic [0:3] CMD_SUB = 4'd2;
  localparam logic [0:3] CMD_SHL = 4'd5;
  localparam logic [0:3] CMD_SHR = 4'd6;

  localparam logic [0:1] RESP_NONE = 2'd0;
  localparam logic [0:1] RESP_OK   = 2'd1;
  localparam logic [0:1] RESP_ERR  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OP2,
    ST_EXEC,
    ST_RESP
  } state_t;

endpackage

// File: rtl/calc1_quad_alu_if.sv
// One requester's link: command/operand in, response code/result out.
interface calc1_quad_alu_if #(parameter int DATA_W = calc1_pkg::DEF_DATA_W);
  logic [0:3]        cmd;
  logic [0:DATA_W-1] data;
  logic [0:DATA_W-1] out_data;
  logic [0:1]        out_resp;

  modport master (output cmd, output data, input out_data, input out_resp);
  modport slave  (input cmd, input data, output out_data, output out_resp);
endinterface

// File: rtl/calc1_port_unit.sv
// One calculator port: IDLE -> OP2 -> EXEC -> RESP FSM with registered
// operands, registered result, and a one-cycle registered response.
module calc1_port_unit
  import calc1_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  calc1_quad_alu_if.slave  bus
);

  state_t            state_q, state_d;
  logic [0:3]        cmd_q;
  logic [0:DATA_W-1] op1_q, op2_q, res_data_q, out_data_q;
  logic [0:1]        res_resp_q, out_resp_q;
  logic [0:DATA_W-1] exec_data;
  logic [0:1]        exec_resp;
  logic [0:DATA_W]   sum;
  logic [0:4]        shamt;

  // NOTE: clocked blocks use non-blocking assignments so every register
  // updates from the values present before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.cmd != CMD_NOP) state_d = ST_OP2;
      ST_OP2:  state_d = ST_EXEC;
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: every output gets a default before the case, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    sum       = {1'b0, op1_q} + {1'b0, op2_q};
    shamt     = op2_q[DATA_W-5:DATA_W-1];
    exec_resp = RESP_ERR;
    exec_data = '0;
    case (cmd_q)
      CMD_ADD: if (!sum[0]) begin
        exec_resp = RESP_OK;
        exec_data = sum[1:DATA_W];
      end
      CMD_SUB: if (op2_q <= op1_q) begin
        exec_resp = RESP_OK;
        exec_data = op1_q - op2_q;
      end
      CMD_SHL: begin
        exec_resp = RESP_OK;
        exec_data = op1_q << shamt;
      end
      CMD_SHR: begin
        exec_resp = RESP_OK;
        exec_data = op1_q >> shamt;
      end
      default: ;
    endcase
  end

  // Commands arriving outside IDLE are dropped simply by not being latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q      <= CMD_NOP;
      op1_q      <= '0;
      op2_q      <= '0;
      res_data_q <= '0;
      res_resp_q <= RESP_NONE;
      out_data_q <= '0;
      out_resp_q <= RESP_NONE;
    end else begin
      if (state_q == ST_IDLE && bus.cmd != CMD_NOP) begin
        cmd_q <= bus.cmd;
        op1_q <= bus.data;
      end
      if (state_q == ST_OP2) op2_q <= bus.data;
      if (state_q == ST_EXEC) begin
        res_data_q <= exec_data;
        res_resp_q <= exec_resp;
      end
      out_resp_q <= (state_q == ST_RESP) ? res_resp_q : RESP_NONE;
      out_data_q <= (state_q == ST_RESP && res_resp_q == RESP_OK) ? res_data_q : '0;
    end
  end

  assign bus.out_data = out_data_q;
  assign bus.out_resp = out_resp_q;

endmodule

// File: rtl/calc1_quad_alu.sv
// Four independent calculator ports behind a shared reset synchronizer
// (asynchronous assert, synchronous release).
module calc1_quad_alu
  import calc1_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [0:3]        req1_cmd_in,
  input  logic [0:DATA_W-1] req1_data_in,
  input  logic [0:3]        req2_cmd_in,
  input  logic [0:DATA_W-1] req2_data_in,
  input  logic [0:3]        req3_cmd_in,
  input  logic [0:DATA_W-1] req3_data_in,
  input  logic [0:3]        req4_cmd_in,
  input  logic [0:DATA_W-1] req4_data_in,
  output logic [0:DATA_W-1] out_data1,
  output logic [0:1]        out_resp1,
  output logic [0:DATA_W-1] out_data2,
  output logic [0:1]        out_resp2,
  output logic [0:DATA_W-1] out_data3,
  output logic [0:1]        out_resp3,
  output logic [0:DATA_W-1] out_data4,
  output logic [0:1]        out_resp4
);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  calc1_quad_alu_if #(.DATA_W(DATA_W)) bus [4] ();

  assign bus[0].cmd  = req1_cmd_in;
  assign bus[0].data = req1_data_in;
  assign bus[1].cmd  = req2_cmd_in;
  assign bus[1].data = req2_data_in;
  assign bus[2].cmd  = req3_cmd_in;
  assign bus[2].data = req3_data_in;
  assign bus[3].cmd  = req4_cmd_in;
  assign bus[3].data = req4_data_in;

  assign out_data1 = bus[0].out_data;
  assign out_resp1 = bus[0].out_resp;
  assign out_data2 = bus[1].out_data;
  assign out_resp2 = bus[1].out_resp;
  assign out_data3 = bus[2].out_data;
  assign out_resp3 = bus[2].out_resp;
  assign out_data4 = bus[3].out_data;
  assign out_resp4 = bus[3].out_resp;

  for (genvar g = 0; g < 4; g++) begin : g_port
    calc1_port_unit #(.DATA_W(DATA_W)) u_port (
      .clk   (c_clk),
      .rst_n (rst_n),
      .bus   (bus[g])
    );
  end

endmodule

// File: tb/tb_calc1_quad_alu.sv
// Directed plus randomized bench for calc1_quad_alu against an arithmetic
// reference model of the command/response rules.
module tb_calc1_quad_alu;

  logic c_clk = 1'b0;
  logic reset = 1'b0;

  logic [0:3]  cmd   [4];
  logic [0:31] data  [4];
  logic [0:31] odata [4];
  logic [0:1]  oresp [4];

  logic [0:3]  t_cmd [4];
  logic [0:31] t_op1 [4];
  logic [0:31] t_op2 [4];

  int checks = 0;
  int errors = 0;

  always #5 c_clk = ~c_clk;

  calc1_quad_alu_if #(.DATA_W(32)) tb_bus [4] ();

  for (genvar g = 0; g < 4; g++) begin : g_link
    assign tb_bus[g].cmd  = cmd[g];
    assign tb_bus[g].data = data[g];
    assign odata[g]       = tb_bus[g].out_data;
    assign oresp[g]       = tb_bus[g].out_resp;
  end

  calc1_quad_alu #(.DATA_W(32)) dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (tb_bus[0].cmd),
    .req1_data_in (tb_bus[0].data),
    .req2_cmd_in  (tb_bus[1].cmd),
    .req2_data_in (tb_bus[1].data),
    .req3_cmd_in  (tb_bus[2].cmd),
    .req3_data_in (tb_bus[2].data),
    .req4_cmd_in  (tb_bus[3].cmd),
    .req4_data_in (tb_bus[3].data),
    .out_data1    (tb_bus[0].out_data),
    .out_resp1    (tb_bus[0].out_resp),
    .out_data2    (tb_bus[1].out_data),
    .out_resp2    (tb_bus[1].out_resp),
    .out_data3    (tb_bus[2].out_data),
    .out_resp3    (tb_bus[2].out_resp),
    .out_data4    (tb_bus[3].out_data),
    .out_resp4    (tb_bus[3].out_resp)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the operand values.
  function automatic void model(input logic [0:3] c, input logic [0:31] a, input logic [0:31] b,
                                output logic [0:1] r, output logic [0:31] d);
    logic [63:0] s;
    r = 2'd2;
    d = 32'd0;
    case (int'(c))
      0: r = 2'd0;
      1: begin
        s = {32'd0, a} + {32'd0, b};
        if (s <= 64'hFFFF_FFFF) begin r = 2'd1; d = s[31:0]; end
      end
      2: if (b <= a) begin r = 2'd1; d = a - b; end
      5: begin r = 2'd1; d = a << (b % 32); end
      6: begin r = 2'd1; d = a >> (b % 32); end
      default: ;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    for (int p = 0; p < 4; p++) begin
      check($sformatf("%s p%0d resp", tag, p + 1), 64'(oresp[p]), 64'd0);
      check($sformatf("%s p%0d data", tag, p + 1), 64'(odata[p]), 64'd0);
    end
  endtask

  // Runs the transactions in t_cmd/t_op1/t_op2 on all ports at once; ports with
  // cmd 0 stay idle. With noise set, active ports see junk commands while busy.
  task automatic run_txn(input string tag, input bit noise);
    logic [0:1]  er [4];
    logic [0:31] ed [4];
    for (int p = 0; p < 4; p++) model(t_cmd[p], t_op1[p], t_op2[p], er[p], ed[p]);
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin cmd[p] = t_cmd[p]; data[p] = t_op1[p]; end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin
      cmd[p]  = (noise && t_cmd[p] != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      data[p] = t_op2[p];
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge c_clk);
      check_idle($sformatf("%s wait%0d", tag, k));
      for (int p = 0; p < 4; p++) begin
        cmd[p]  = (noise && t_cmd[p] != 0) ? 4'($urandom_range(1, 15)) : 4'd0;
        data[p] = $urandom;
      end
    end
    @(negedge c_clk);
    for (int p = 0; p < 4; p++) begin
      check($sformatf("%s p%0d resp", tag, p + 1), 64'(oresp[p]), 64'(er[p]));
      check($sformatf("%s p%0d data", tag, p + 1), 64'(odata[p]), 64'(ed[p]));
      cmd[p] = 4'd0;
    end
    @(negedge c_clk);
    check_idle($sformatf("%s after", tag));
  endtask

  task automatic one(input string tag, input int c, input logic [0:31] a, input logic [0:31] b);
    for (int p = 0; p < 4; p++) begin t_cmd[p] = 4'd0; t_op1[p] = '0; t_op2[p] = '0; end
    t_cmd[0] = 4'(c);
    t_op1[0] = a;
    t_op2[0] = b;
    run_txn(tag, 1'b0);
  endtask

  initial begin
    logic [0:31] x;
    int sel;
    for (int p = 0; p < 4; p++) begin cmd[p] = 4'd0; data[p] = '0; end

    reset = 1'b0;
    repeat (4) @(negedge c_clk);
    check_idle("in_reset");
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge c_clk);
      check_idle($sformatf("post_reset%0d", k));
    end

    one("add_small",  1, 32'h0000_0001, 32'h1FFF_FFFF);
    one("add_mid",    1, 32'h1FFF_FFFF, 32'h1FFF_FFFF);
    one("add_zero",   1, 32'h0,         32'h0);
    one("add_ovf",    1, 32'hFFFF_FFFF, 32'h1);
    one("sub_under",  2, 32'd1,         32'd15);
    one("sub_ok",     2, 32'd15,        32'd1);
    one("sub_equal",  2, 32'd9,         32'd9);
    one("cmd3",       3, 32'd1,         32'd0);
    one("cmd4",       4, 32'd1,         32'd0);
    one("cmd15",      15, 32'd7,        32'd3);
    x = 32'd1;
    for (int i = 0; i < 15; i++) begin
      one($sformatf("sweep%0d", i), 1, x, 32'd0);
      x = x << 1;
    end
    one("shl31",      5, 32'h0000_0001, 32'd31);
    one("shr_wrap",   6, 32'h8000_0000, 32'h0000_0021);
    one("shl_upper",  5, 32'h0000_00F0, 32'hFFFF_FFE4);

    for (int p = 0; p < 4; p++) begin
      t_cmd[p] = 4'd1;
      t_op1[p] = 32'(p * 32'h1000_0000 + 1);
      t_op2[p] = 32'(p + 100);
    end
    run_txn("all_add", 1'b1);

    // Reset arriving while port 1 is in EXEC discards the request.
    @(negedge c_clk);
    cmd[0] = 4'd1; data[0] = 32'd5;
    @(negedge c_clk);
    cmd[0] = 4'd0; data[0] = 32'd7;
    @(negedge c_clk);
    reset = 1'b0;
    #1;
    check_idle("rst_exec_now");
    for (int k = 0; k < 2; k++) begin
      @(negedge c_clk);
      check_idle($sformatf("rst_exec_held%0d", k));
    end
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge c_clk);
      check_idle($sformatf("rst_exec_rel%0d", k));
    end
    one("after_rst", 2, 32'd100, 32'd58);

    for (int i = 0; i < 30; i++) begin
      for (int p = 0; p < 4; p++) begin
        sel = $urandom_range(0, 9);
        case (sel)
          0:       t_cmd[p] = 4'd0;
          1, 2:    t_cmd[p] = 4'd1;
          3, 4:    t_cmd[p] = 4'd2;
          5:       t_cmd[p] = 4'd5;
          6:       t_cmd[p] = 4'd6;
          default: begin
            t_cmd[p] = 4'($urandom_range(3, 15));
            if (t_cmd[p] == 4'd5 || t_cmd[p] == 4'd6) t_cmd[p] = 4'd4;
          end
        endcase
        t_op1[p] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 255));
        t_op2[p] = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 255));
      end
      run_txn($sformatf("rand%0d", i), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
